run_sequencer: RTL
==================

// Module: run_sequencer
// PURPOSE
//  Run controller wrapped around the 9-bit-ISA core. Preloads data memory through a
//  load handshake, holds the core in reset, then releases it and counts cycles until
//  core done or timeout. After the run it gives data memory to a readback port.
//  Sits beside top_level: drives core reset and owns the data-memory external-port mux.
// PARAMETERS
//  AW       8     data-memory address width (256 bytes)
//  CW       16    cycle-counter width
//  BOOT_CYC 2     cycles core_reset stays high after load completes (1..15)
//  TIMEOUT  4000  RUN cycles before abandon (must be < 2**CW)
// PORTS
//  clk          in   1   clock
//  reset        in   1   asynchronous, active-high reset
//  start        in   1   one-cycle pulse; begins a run from IDLE/DONE/TMO
//  ld_valid     in   1   preload beat valid
//  ld_ready     out  1   preload beat accepted (LOAD state only)
//  ld_last      in   1   marks final preload beat
//  ld_addr      in   AW  preload address
//  ld_data      in   8   preload byte
//  core_done    in   1   done flag from core
//  core_reset   out  1   drives core reset
//  mem_own      out  1   1: external port drives data memory, 0: core drives it
//  mem_wr_en    out  1   external write strobe
//  mem_addr     out  AW  external address (ld_addr in LOAD, rb_addr otherwise)
//  mem_dat      out  8   external write data (= ld_data)
//  rb_addr      in   AW  readback address
//  mem_rd_data  in   8   data-memory read data
//  rb_data      out  8   readback data; 0 unless state is DONE or TMO
//  busy         out  1   state is LOAD, BOOT or RUN
//  finished     out  1   state is DONE
//  timed_out    out  1   state is TMO
//  cycles       out  CW  RUN cycle count; held after run ends
// BEHAVIOUR
//  Reset values: state=IDLE, core_reset=1, mem_own=1, cycles=0, boot count=0.
//   All status outputs are 0.
//  States: IDLE, LOAD, BOOT, RUN, DONE, TMO. All outputs decode from registered state.
//  IDLE: start -> LOAD and clear cycles.
//  LOAD: ld_ready=1. mem_wr_en = ld_valid (combinational, same cycle, no wait states).
//   When ld_valid & ld_last are both high, that beat is written -> BOOT.
//   A zero-beat run is not supported; at least one beat is required.
//  BOOT: core_reset=1 for exactly BOOT_CYC cycles -> RUN.
//  RUN: core_reset=0, mem_own=0, mem_wr_en=0. cycles increments by 1 every RUN cycle.
//   core_done sampled high -> DONE; cycles is not incremented on that cycle.
//   cycles == TIMEOUT-1 with core_done low -> TMO.
//   core_done and timeout in the same cycle -> DONE wins.
//  DONE/TMO: core_reset=1 (freezes core), mem_own=1, rb_data = mem_rd_data
//   (combinational read). start -> LOAD and clear cycles.
//  start is ignored in LOAD, BOOT and RUN. ld_valid is ignored outside LOAD
//   (mem_wr_en stays 0).
//  Counter saturates at 2**CW-1 and never wraps; unreachable when TIMEOUT is legal.
//  Reset mid-operation: immediate return to IDLE; core held in reset. Memory contents
//   are not cleared.
// CONFIGURATION
//  RUN_SEQ_ABORT_EN defined: adds input abort (1 bit). abort high in LOAD, BOOT or RUN
//   -> IDLE next cycle, core_reset=1, cycles is held. abort has priority over
//   core_done, timeout and ld_last.
//  Macro undefined: no abort port; a run ends only through DONE, TMO or reset.
// STRUCTURE
//  Package run_seq_pkg: typedef enum logic[2:0] seq_state_t
//   {IDLE,LOAD,BOOT,RUN,DONE,TMO}; localparam defaults for AW/CW/BOOT_CYC/TIMEOUT.
//  One sub-module, sat_counter (clear, enable, saturate at max). It serves as the cycle
//   counter; a second instance serves as the BOOT counter.
//  Next-state logic in always_comb; state register in always_ff with async reset.
// TESTING
//  1. Reset, start, 3 beats (addr 0,1,2 = 8'h11,22,33; last on beat 3) -> 3 mem_wr_en
//     pulses; BOOT lasts exactly 2 cycles; then core_reset=0.
//  2. core_done raised 10 RUN cycles after core_reset falls -> finished=1, cycles=10,
//     core_reset=1; rb_addr=1 -> rb_data=8'h22.
//  3. core_done never raised, TIMEOUT=20 -> timed_out=1 with cycles=20;
//     core_done then raised -> state stays TMO.
//  4. core_done high on the timeout cycle -> finished=1, timed_out=0.
//  5. Reset asserted mid-RUN -> core_reset=1, busy=0, cycles=0 with no clock edge;
//     start pulsed during LOAD -> no effect.
//  6. RUN_SEQ_ABORT_EN: abort in BOOT -> IDLE next cycle, core_reset never falls.

Source files
------------

// File: rtl/run_seq_pkg.sv
// Shared types and default parameters for the run sequencer.
package run_seq_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    BOOT = 3'd2,
    RUN  = 3'd3,
    DONE = 3'd4,
    TMO  = 3'd5
  } seq_state_t;

  localparam int AW_DEF       = 8;
  localparam int CW_DEF       = 16;
  localparam int BOOT_CYC_DEF = 2;
  localparam int TIMEOUT_DEF  = 4000;
  localparam int BOOT_W       = 4;

  function automatic logic is_busy(input seq_state_t s);
    return (s == LOAD) || (s == BOOT) || (s == RUN);
  endfunction

endpackage

// File: rtl/run_sequencer_sat_counter.sv
// Up-counter with synchronous clear and enable that holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/run_sequencer.sv
// Run controller: preload data memory, boot the core, time the run, then expose readback.
// Optional RUN_SEQ_ABORT_EN adds an abort input that returns LOAD/BOOT/RUN to IDLE.
//
// state | meaning
// IDLE  | core held in reset, waiting for start
// LOAD  | accepting preload beats into data memory
// BOOT  | core still in reset for BOOT_CYC cycles after load
// RUN   | core running, cycle counter advancing
// DONE  | core reported done, memory readable
// TMO   | run abandoned at TIMEOUT, memory readable
module run_sequencer
  import run_seq_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int CW       = CW_DEF,
  parameter int BOOT_CYC = BOOT_CYC_DEF,
  parameter int TIMEOUT  = TIMEOUT_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
`ifdef RUN_SEQ_ABORT_EN
  input  logic          abort,
`endif
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic          ld_last,
  input  logic [AW-1:0] ld_addr,
  input  logic [7:0]    ld_data,
  input  logic          core_done,
  output logic          core_reset,
  output logic          mem_own,
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_dat,
  input  logic [AW-1:0] rb_addr,
  input  logic [7:0]    mem_rd_data,
  output logic [7:0]    rb_data,
  output logic          busy,
  output logic          finished,
  output logic          timed_out,
  output logic [CW-1:0] cycles
);

  localparam logic [CW-1:0]     TMO_LAST  = CW'(TIMEOUT - 1);
  localparam logic [BOOT_W-1:0] BOOT_LAST = BOOT_W'(BOOT_CYC - 1);

  seq_state_t        state_q;
  seq_state_t        state_d;
  logic              start_ok;
  logic              abort_hit;
  logic [BOOT_W-1:0] boot_cnt;
  logic [CW-1:0]     cycles_cnt;

  assign start_ok = start && ((state_q == IDLE) || (state_q == DONE) || (state_q == TMO));

`ifdef RUN_SEQ_ABORT_EN
  assign abort_hit = abort && is_busy(state_q);
`else
  assign abort_hit = 1'b0;
`endif

  // Boot counter idles at zero outside BOOT so every boot starts from a clean count.
  sat_counter #(.W(BOOT_W)) u_boot_cnt (
    .clk (clk),
    .rst (reset),
    .clr (state_q != BOOT),
    .en  (state_q == BOOT),
    .cnt (boot_cnt)
  );

  sat_counter #(.W(CW)) u_cycle_cnt (
    .clk (clk),
    .rst (reset),
    .clr (start_ok),
    .en  ((state_q == RUN) && !core_done && !abort_hit),
    .cnt (cycles_cnt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (abort_hit) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE, TMO: if (start) state_d = LOAD;
        LOAD:            if (ld_valid && ld_last) state_d = BOOT;
        BOOT:            if (boot_cnt == BOOT_LAST) state_d = RUN;
        // done outranks timeout when both land on the same cycle
        RUN: begin
          if (core_done)                    state_d = DONE;
          else if (cycles_cnt == TMO_LAST)  state_d = TMO;
        end
        default:         state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    ld_ready   = 1'b0;
    core_reset = 1'b1;
    mem_own    = 1'b1;
    mem_wr_en  = 1'b0;
    mem_addr   = rb_addr;
    rb_data    = 8'h00;
    busy       = is_busy(state_q);
    finished   = 1'b0;
    timed_out  = 1'b0;
    case (state_q)
      LOAD: begin
        ld_ready  = 1'b1;
        mem_wr_en = ld_valid;
        mem_addr  = ld_addr;
      end
      RUN: begin
        core_reset = 1'b0;
        mem_own    = 1'b0;
      end
      DONE: begin
        finished = 1'b1;
        rb_data  = mem_rd_data;
      end
      TMO: begin
        timed_out = 1'b1;
        rb_data   = mem_rd_data;
      end
      default: ;
    endcase
  end

  assign mem_dat = ld_data;
  assign cycles  = cycles_cnt;

endmodule
